// File: rtl/disparity_row_scheduler.sv
// Row sequencer for the stereo disparity datapath: waits for both rows, sweeps every
// block over offsets 0..MAX_DISP through the SSD engine, then streams one disparity per pixel.
module disparity_row_scheduler #(
    parameter int ROW_PIXELS = 800,
    parameter int BLK        = 4,
    parameter int MAX_DISP   = 9,
    parameter int COST_W     = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid_l,
    input  logic              i_valid_r,
    output logic              o_eng_req,
    output logic [7:0]        o_eng_blk,
    output logic [3:0]        o_eng_off,
    input  logic              i_cost_valid,
    input  logic [COST_W-1:0] i_cost,
    input  logic              i_cost_skip,
    output logic              o_valid,
    output logic [3:0]        o_disp,
    input  logic              i_ready,
    output logic              o_row_done,
    output logic              o_busy
);

    localparam int NBLK  = ROW_PIXELS / BLK;
    localparam int SUB_W = (BLK > 1) ? $clog2(BLK) : 1;

    localparam logic [7:0]       LAST_BLK = 8'(NBLK - 1);
    localparam logic [3:0]       LAST_OFF = 4'(MAX_DISP);
    localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(BLK - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;

    logic [2:0]        r_state;
    logic              r_flag_l;
    logic              r_flag_r;
    logic [7:0]        r_blk;
    logic [3:0]        r_off;
    logic [COST_W-1:0] r_best;
    logic [3:0]        r_bdisp;
    logic [7:0]        r_out_blk;
    logic [SUB_W-1:0]  r_out_sub;
    logic              r_eng_req;
    logic [7:0]        r_eng_blk;
    logic [3:0]        r_eng_off;
    logic              r_row_done;
    logic [3:0]        r_disp_buf [NBLK];

    logic              w_start;
    logic              w_in_range;
    logic              w_accept;
    logic              w_last_pix;
    logic [2:0]        w_state_nxt;
    logic [7:0]        w_blk_nxt;
    logic [3:0]        w_off_nxt;
    logic [COST_W-1:0] w_best_nxt;
    logic [3:0]        w_bdisp_nxt;
    logic              w_commit;
    logic              w_req_nxt;

    // A window at (blk, off) reads right-row pixels up to blk*BLK+off+BLK-1.
    function automatic logic f_in_range(input logic [7:0] blk, input logic [3:0] off);
        return (int'(blk) * BLK + int'(off) + BLK) <= ROW_PIXELS;
    endfunction

    assign w_start    = (r_flag_l | i_valid_l) && (r_flag_r | i_valid_r);
    assign w_in_range = f_in_range(r_blk, r_off);
    assign w_accept   = (r_state == S_OUTPUT) && i_ready;
    assign w_last_pix = (r_out_blk == LAST_BLK) && (r_out_sub == LAST_SUB);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_blk_nxt   = r_blk;
        w_off_nxt   = r_off;
        w_best_nxt  = r_best;
        w_bdisp_nxt = r_bdisp;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_ISSUE;
                    w_blk_nxt   = '0;
                    w_off_nxt   = '0;
                    w_best_nxt  = '1;
                    w_bdisp_nxt = '0;
                end
            end
            S_ISSUE: begin
                // Out-of-range offsets are consumed here as if the engine had skipped them.
                if (w_in_range) begin
                    w_state_nxt = S_WAIT;
                end else if (r_off == LAST_OFF) begin
                    w_state_nxt = S_COMMIT;
                end else begin
                    w_off_nxt = r_off + 4'd1;
                end
            end
            S_WAIT: begin
                if (i_cost_valid) begin
                    if (!i_cost_skip && (i_cost < r_best)) begin
                        w_best_nxt  = i_cost;
                        w_bdisp_nxt = r_off;
                    end
                    if (r_off == LAST_OFF) begin
                        w_state_nxt = S_COMMIT;
                    end else begin
                        w_off_nxt   = r_off + 4'd1;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_best_nxt  = '1;
                w_bdisp_nxt = '0;
                w_off_nxt   = '0;
                if (r_blk == LAST_BLK) begin
                    w_state_nxt = S_OUTPUT;
                end else begin
                    w_blk_nxt   = r_blk + 8'd1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_OUTPUT: begin
                if (w_accept && w_last_pix) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The request is registered one cycle ahead so it lines up with the ISSUE cycle.
    assign w_req_nxt = (w_state_nxt == S_ISSUE) && f_in_range(w_blk_nxt, w_off_nxt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_flag_l   <= 1'b0;
            r_flag_r   <= 1'b0;
            r_blk      <= '0;
            r_off      <= '0;
            r_best     <= '1;
            r_bdisp    <= '0;
            r_out_blk  <= '0;
            r_out_sub  <= '0;
            r_eng_req  <= 1'b0;
            r_eng_blk  <= '0;
            r_eng_off  <= '0;
            r_row_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_blk   <= w_blk_nxt;
            r_off   <= w_off_nxt;
            r_best  <= w_best_nxt;
            r_bdisp <= w_bdisp_nxt;

            if ((r_state == S_IDLE) && w_start) begin
                r_flag_l <= 1'b0;
                r_flag_r <= 1'b0;
            end else begin
                r_flag_l <= r_flag_l | i_valid_l;
                r_flag_r <= r_flag_r | i_valid_r;
            end

            r_eng_req <= w_req_nxt;
            if (w_req_nxt) begin
                r_eng_blk <= w_blk_nxt;
                r_eng_off <= w_off_nxt;
            end

            r_row_done <= w_accept && w_last_pix;

            if (w_commit) begin
                r_out_blk <= '0;
                r_out_sub <= '0;
            end else if (w_accept) begin
                if (r_out_sub == LAST_SUB) begin
                    r_out_sub <= '0;
                    r_out_blk <= r_out_blk + 8'd1;
                end else begin
                    r_out_sub <= r_out_sub + 1'b1;
                end
            end
        end
    end

    // NOTE: the disparity buffer is always fully written before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_disp_buf[r_blk] <= r_bdisp;
        end
    end

    assign o_eng_req  = r_eng_req;
    assign o_eng_blk  = r_eng_blk;
    assign o_eng_off  = r_eng_off;
    assign o_valid    = (r_state == S_OUTPUT);
    assign o_disp     = (r_state == S_OUTPUT) ? r_disp_buf[r_out_blk] : 4'd0;
    assign o_row_done = r_row_done;
    assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_disparity_row_scheduler.sv
// Randomized bench for disparity_row_scheduler: an engine model answers requests from a cost
// table, and a per-row reference (plain arg-min over in-range offsets) predicts requests and pixels.
module tb_disparity_row_scheduler;

    localparam int ROW_PIXELS = 800;
    localparam int BLK        = 4;
    localparam int MAX_DISP   = 9;
    localparam int COST_W     = 17;
    localparam int NBLK       = ROW_PIXELS / BLK;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_valid_l;
    logic              i_valid_r;
    logic              o_eng_req;
    logic [7:0]        o_eng_blk;
    logic [3:0]        o_eng_off;
    logic              i_cost_valid;
    logic [COST_W-1:0] i_cost;
    logic              i_cost_skip;
    logic              o_valid;
    logic [3:0]        o_disp;
    logic              i_ready;
    logic              o_row_done;
    logic              o_busy;

    disparity_row_scheduler #(
        .ROW_PIXELS(ROW_PIXELS), .BLK(BLK), .MAX_DISP(MAX_DISP), .COST_W(COST_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_valid_l(i_valid_l), .i_valid_r(i_valid_r),
        .o_eng_req(o_eng_req), .o_eng_blk(o_eng_blk), .o_eng_off(o_eng_off),
        .i_cost_valid(i_cost_valid), .i_cost(i_cost), .i_cost_skip(i_cost_skip),
        .o_valid(o_valid), .o_disp(o_disp), .i_ready(i_ready),
        .o_row_done(o_row_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct { int blk; int off; } req_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cost_tab [NBLK][MAX_DISP+1];
    bit   skip_tab [NBLK][MAX_DISP+1];
    int   row_exp  [NBLK];
    int   out_exp  [NBLK];
    req_t req_q [$];
    int   eng_lat_min = 1;
    int   eng_lat_max = 1;
    bit   noise_en = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: cost = 100 - off everywhere; mode 1: random costs/skips with fixed blocks 3 and 7.
    task automatic prepare_row(input int mode);
        for (int b = 0; b < NBLK; b++) begin
            for (int o = 0; o <= MAX_DISP; o++) begin
                if (mode == 0) begin
                    cost_tab[b][o] = 100 - o;
                    skip_tab[b][o] = 1'b0;
                end else begin
                    cost_tab[b][o] = ($urandom_range(0, 19) == 0) ? (1 << COST_W) - 1
                                                                  : int'($urandom_range(0, 300));
                    skip_tab[b][o] = ($urandom_range(0, 9) == 0);
                end
            end
        end
        if (mode == 1) begin
            for (int o = 0; o <= MAX_DISP; o++) begin
                cost_tab[3][o] = (o == 0) ? 50 : (o <= 2) ? 20 : (o == 3) ? 80 : 100 + o;
                skip_tab[3][o] = 1'b0;
                skip_tab[7][o] = 1'b1;
            end
        end
        req_q.delete();
        for (int b = 0; b < NBLK; b++) begin
            longint best = (64'd1 << COST_W) - 1;
            int     bd   = 0;
            for (int o = 0; o <= MAX_DISP; o++) begin
                if (b * BLK + o + BLK <= ROW_PIXELS) begin
                    req_q.push_back('{blk: b, off: o});
                    if (!skip_tab[b][o] && cost_tab[b][o] < best) begin
                        best = cost_tab[b][o];
                        bd   = o;
                    end
                end
            end
            row_exp[b] = bd;
        end
    endtask

    // Engine model: one response per request after a random latency; optional noise strobes.
    initial begin
        int         resp_cnt;
        bit         resp_busy;
        bit         hold_chk;
        logic [7:0] last_b;
        logic [3:0] last_o;
        int         pend_cost;
        bit         pend_skip;
        req_t       e;
        resp_cnt     = 0;
        hold_chk     = 0;
        last_b       = '0;
        last_o       = '0;
        pend_cost    = 0;
        pend_skip    = 0;
        i_cost_valid = 1'b0;
        i_cost       = '0;
        i_cost_skip  = 1'b0;
        forever begin
            tick();
            i_cost_valid = 1'b0;
            i_cost       = COST_W'($urandom);
            i_cost_skip  = 1'($urandom_range(0, 1));
            resp_busy    = (resp_cnt > 0);
            if (hold_chk) begin
                check("hold_blk", o_eng_blk, last_b);
                check("hold_off", o_eng_off, last_o);
                check("req_one_cycle", o_eng_req, 0);
                hold_chk = 0;
            end
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    i_cost_valid = 1'b1;
                    i_cost       = COST_W'(pend_cost);
                    i_cost_skip  = pend_skip;
                end
            end else if (noise_en && $urandom_range(0, 3) == 0) begin
                i_cost_valid = 1'b1;
                i_cost       = '0;
                i_cost_skip  = 1'b0;
            end
            if (o_eng_req === 1'b1) begin
                check("req_while_outstanding", resp_busy, 0);
                if (req_q.size() == 0) begin
                    check("req_unexpected", 1, 0);
                end else begin
                    e = req_q.pop_front();
                    check("req_blk", o_eng_blk, e.blk);
                    check("req_off", o_eng_off, e.off);
                end
                if (o_eng_blk < NBLK && o_eng_off <= MAX_DISP) begin
                    pend_cost = cost_tab[o_eng_blk][o_eng_off];
                    pend_skip = skip_tab[o_eng_blk][o_eng_off];
                end else begin
                    pend_cost = 0;
                    pend_skip = 1'b1;
                end
                resp_cnt = $urandom_range(eng_lat_min, eng_lat_max);
                last_b   = o_eng_blk;
                last_o   = o_eng_off;
                hold_chk = 1;
            end
        end
    end

    // Waits for the output phase, then drains the row; optionally loads the next row meanwhile.
    task automatic run_output(input int stall_pct, input bit pulse_next);
        int         budget = 30000;
        int         pix = 0;
        int         cyc = 0;
        bit         stalled = 0;
        logic [3:0] held = '0;
        while (o_valid !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        check("output_reached", o_valid, 1);
        if (o_valid !== 1'b1) return;
        check("requests_left", req_q.size(), 0);
        out_exp = row_exp;
        if (pulse_next) prepare_row(0);
        noise_en = 1;
        while (pix < ROW_PIXELS && cyc < 4 * ROW_PIXELS) begin
            i_ready   = ($urandom_range(0, 99) >= stall_pct);
            i_valid_l = pulse_next && (cyc == 100);
            i_valid_r = pulse_next && (cyc == 500);
            check("out_valid", o_valid, 1);
            if (stalled) check("disp_stable", o_disp, held);
            if (i_ready) begin
                check("disp_pix", o_disp, out_exp[pix / BLK]);
                pix++;
                stalled = 0;
            end else begin
                stalled = 1;
                held    = o_disp;
            end
            tick();
            cyc++;
        end
        i_ready   = 1'b0;
        i_valid_l = 1'b0;
        i_valid_r = 1'b0;
        noise_en  = 0;
        check("accept_count", pix, ROW_PIXELS);
        check("row_done_pulse", o_row_done, 1);
        check("idle_after_row", o_busy, 0);
        check("valid_after_row", o_valid, 0);
        if (stall_pct == 0) check("throughput_cycles", cyc, ROW_PIXELS);
        tick();
        check("row_done_single", o_row_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit early_req;
        bit any_req;
        bit any_busy;
        int budget;
        rst_n     = 1'b0;
        i_valid_l = 1'b0;
        i_valid_r = 1'b0;
        i_ready   = 1'b0;
        repeat (3) tick();
        check("rst_eng_req", o_eng_req, 0);
        check("rst_eng_blk", o_eng_blk, 0);
        check("rst_eng_off", o_eng_off, 0);
        check("rst_valid", o_valid, 0);
        check("rst_disp", o_disp, 0);
        check("rst_row_done", o_row_done, 0);
        check("rst_busy", o_busy, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", o_busy, 0);

        // Row 1: simultaneous pulses, cost = 100 - off, latency 1, full throughput.
        prepare_row(0);
        eng_lat_min = 1;
        eng_lat_max = 1;
        i_valid_l = 1'b1;
        i_valid_r = 1'b1;
        tick();
        i_valid_l = 1'b0;
        i_valid_r = 1'b0;
        check("start_req", o_eng_req, 1);
        check("start_blk", o_eng_blk, 0);
        check("start_off", o_eng_off, 0);
        check("start_busy", o_busy, 1);
        run_output(0, 0);

        // Row 2: left at cycle 5, right at cycle 40; random costs; 30% stalls.
        prepare_row(1);
        eng_lat_max = 2;
        early_req = 0;
        for (int c = 0; c <= 41; c++) begin
            i_valid_l = (c == 5);
            i_valid_r = (c == 40);
            if (c == 39) check("one_flag_idle", o_busy, 0);
            if (c == 41) begin
                check("late_start_req", o_eng_req, 1);
                check("late_start_blk", o_eng_blk, 0);
                check("late_start_off", o_eng_off, 0);
            end else begin
                early_req |= (o_eng_req === 1'b1);
            end
            if (c < 41) tick();
        end
        check("no_early_req", early_req, 0);
        run_output(30, 0);

        // Row 3: abort with reset while waiting on block 50; the late response must be ignored.
        prepare_row(1);
        eng_lat_min = 5;
        eng_lat_max = 5;
        i_valid_l = 1'b1;
        i_valid_r = 1'b1;
        tick();
        i_valid_l = 1'b0;
        i_valid_r = 1'b0;
        budget = 20000;
        while (!(o_eng_req === 1'b1 && o_eng_blk == 8'd50) && budget > 0) begin
            tick();
            budget--;
        end
        check("reached_blk50", o_eng_blk, 50);
        tick();
        check("busy_in_wait", o_busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", o_busy, 0);
        check("abort_req", o_eng_req, 0);
        check("abort_valid", o_valid, 0);
        any_req  = 0;
        any_busy = 0;
        repeat (10) begin
            tick();
            any_req  |= (o_eng_req === 1'b1);
            any_busy |= (o_busy === 1'b1);
        end
        check("stray_cost_no_req", any_req, 0);
        check("stray_cost_idle", any_busy, 0);

        // Row 4: separate pulses restart at block 0; next row is armed during output.
        prepare_row(1);
        eng_lat_min = 1;
        eng_lat_max = 2;
        i_valid_l = 1'b1;
        tick();
        i_valid_l = 1'b0;
        repeat (3) tick();
        check("left_only_idle", o_busy, 0);
        i_valid_r = 1'b1;
        tick();
        i_valid_r = 1'b0;
        check("restart_req", o_eng_req, 1);
        check("restart_blk", o_eng_blk, 0);
        run_output(30, 1);
        check("next_row_req", o_eng_req, 1);
        check("next_row_busy", o_busy, 1);

        // Row 5: the row armed during output, full throughput.
        run_output(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
